sblk_act_feeder: RTL and testbench

Activation-side responder for the sub-block controller's act load handshake. On each one-cycle `act_in_req` pulse it streams one batch of `n_tp*n_tn*N_TILE` activation words from an external activation source SRAM with `act_in_vld` asserted. The word order matches the controller's act-buffer write order. The block sits between the activation source memory and the sub-block, and is driven by the same instruction word the sub-block controller receives.

---
 rtl/sblk_pkg.sv | 42 ++++
 rtl/sblk_act_feeder_if.sv | 56 +++++
 rtl/sblk_vld_pipe.sv | 48 ++++
 rtl/sblk_act_feeder.sv | 246 ++++++++++++++++++++++++
 tb/tb_sblk_act_feeder.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sblk_pkg.sv
// -----------------------------------------------------------------------------
// sblk_pkg
// Shared definitions for the sub-block activation feeder:
//   - instruction field widths and total instruction width
//   - packed view of the instruction word (fields tn, tm, tp, ln, lp from LSB)
//   - feeder FSM state encoding
//   - legality check for a freshly loaded instruction
// Optional feature macro used by files importing this package:
//   SBLK_FEED_CHKSUM_EN (per-batch XOR checksum outputs).
// -----------------------------------------------------------------------------
package sblk_pkg;

    localparam int WID_INST_TN = 3;
    localparam int WID_INST_TM = 3;
    localparam int WID_INST_TP = 2;
    localparam int WID_INST_LN = 3;
    localparam int WID_INST_LP = 3;
    localparam int WID_INST    = WID_INST_TN + WID_INST_TM + WID_INST_TP
                               + WID_INST_LN + WID_INST_LP;

    // Packed structs list the MSB field first, so lp..tn maps tn onto the LSBs.
    typedef struct packed {
        logic [WID_INST_LP-1:0] lp;
        logic [WID_INST_LN-1:0] ln;
        logic [WID_INST_TP-1:0] tp;
        logic [WID_INST_TM-1:0] tm;
        logic [WID_INST_TN-1:0] tn;
    } inst_fields_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_REQ = 2'd1,
        ST_ISSUE    = 2'd2,
        ST_DRAIN    = 2'd3
    } feed_state_t;

    // tm does not shape the activation stream, so a zero tm is acceptable.
    function automatic logic inst_is_legal(input inst_fields_t f);
        return (|f.tn) && (|f.tp) && (|f.ln) && (|f.lp);
    endfunction

endpackage

// File: rtl/sblk_act_feeder_if.sv
// -----------------------------------------------------------------------------
// sblk_act_feeder_if
// Bundles the instruction, request, source-SRAM and activation-output signals
// of the feeder.
//   master : instruction/request source and the source SRAM read-data side
//   slave  : the feeder itself
// Signals:
//   inst_data/inst_en    instruction word and load strobe
//   act_in_req           one-cycle batch request
//   act_src_rd_en/addr   source SRAM read port (feeder -> SRAM)
//   act_src_rd_data      source SRAM read data, RD_LAT cycles after rd_en
//   act_in_vld/act_in    activation word stream to the sub-block
//   status_feed          instruction active
//   err_flag             sticky errors [0] request overflow, [1] illegal config
//   batch_chksum/chksum_vld  only when SBLK_FEED_CHKSUM_EN is defined
// -----------------------------------------------------------------------------
interface sblk_act_feeder_if #(
    parameter int WID_ACT     = 8,
    parameter int WID_SRCADDR = 12
) ();
    import sblk_pkg::*;

    logic [WID_INST-1:0]    inst_data;
    logic                   inst_en;
    logic                   act_in_req;
    logic                   act_src_rd_en;
    logic [WID_SRCADDR-1:0] act_src_rd_addr;
    logic [2*WID_ACT-1:0]   act_src_rd_data;
    logic                   act_in_vld;
    logic [2*WID_ACT-1:0]   act_in;
    logic                   status_feed;
    logic [1:0]             err_flag;
`ifdef SBLK_FEED_CHKSUM_EN
    logic [2*WID_ACT-1:0]   batch_chksum;
    logic                   chksum_vld;
`endif

    modport master (
        output inst_data, inst_en, act_in_req, act_src_rd_data,
        input  act_src_rd_en, act_src_rd_addr, act_in_vld, act_in,
        input  status_feed, err_flag
`ifdef SBLK_FEED_CHKSUM_EN
        , input batch_chksum, chksum_vld
`endif
    );

    modport slave (
        input  inst_data, inst_en, act_in_req, act_src_rd_data,
        output act_src_rd_en, act_src_rd_addr, act_in_vld, act_in,
        output status_feed, err_flag
`ifdef SBLK_FEED_CHKSUM_EN
        , output batch_chksum, chksum_vld
`endif
    );

endinterface

// File: rtl/sblk_vld_pipe.sv
// -----------------------------------------------------------------------------
// sblk_vld_pipe
// DEPTH-stage valid shift register that aligns the read enable with the
// returning SRAM data. A synchronous flush clears every stage and wins over
// the value being shifted in on the same edge.
// Ports:
//   clk_l    clock
//   rst      asynchronous active-high reset
//   i_flush  synchronous clear of all stages
//   i_vld    valid in (read enable)
//   o_vld    valid out, i_vld delayed DEPTH cycles
// -----------------------------------------------------------------------------
module sblk_vld_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk_l,
    input  logic rst,
    input  logic i_flush,
    input  logic i_vld,
    output logic o_vld
);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic w_din;
            logic r_q;

            if (gi == 0) begin : g_head
                assign w_din = i_vld;
            end else begin : g_body
                assign w_din = g_stage[gi-1].r_q;
            end

            always_ff @(posedge clk_l or posedge rst) begin
                if (rst) begin
                    r_q <= 1'b0;
                end else if (i_flush) begin
                    r_q <= 1'b0;
                end else begin
                    r_q <= w_din;
                end
            end
        end
    endgenerate

    assign o_vld = g_stage[DEPTH-1].r_q;

endmodule

// File: rtl/sblk_act_feeder.sv
// -----------------------------------------------------------------------------
// sblk_act_feeder
// Activation-side responder for the sub-block act load handshake. Each
// act_in_req streams one batch of n_tp*n_tn*N_TILE words from the source
// SRAM to the sub-block, address = cnt_lp*batch_len + cnt_word. Activations
// are reused across ln, so only lp moves the base address.
// Ports:
//   clk_l  clock
//   rst    asynchronous active-high reset
//   bus    sblk_act_feeder_if.slave (instruction, request, SRAM read port,
//          activation stream, status and sticky error flags)
// Optional feature: define SBLK_FEED_CHKSUM_EN to add batch_chksum/chksum_vld,
// the XOR of every act_in word of a batch, presented one cycle after the
// batch's last valid word.
// -----------------------------------------------------------------------------
module sblk_act_feeder #(
    parameter int N_TILE      = 4,
    parameter int WID_ACT     = 8,
    parameter int WID_SRCADDR = 12,
    parameter int RD_LAT      = 2
) (
    input  logic               clk_l,
    input  logic               rst,
    sblk_act_feeder_if.slave   bus
);
    import sblk_pkg::*;

    localparam int WID_N_TILE = $clog2(N_TILE);
    localparam int WID_BLEN   = WID_INST_TP + WID_INST_TN + WID_N_TILE;
    localparam int WID_DRAIN  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    feed_state_t            r_state;
    feed_state_t            w_state_next;

    inst_fields_t           w_inst;
    logic                   w_inst_legal;
    logic [WID_BLEN-1:0]    w_batch_len;

    logic [WID_BLEN-1:0]    r_batch_len;
    logic [WID_INST_LN-1:0] r_n_ln;
    logic [WID_INST_LP-1:0] r_n_lp;
    logic [WID_BLEN-1:0]    r_cnt_word;
    logic [WID_INST_LN-1:0] r_cnt_ln;
    logic [WID_INST_LP-1:0] r_cnt_lp;
    logic [WID_DRAIN-1:0]   r_drain_cnt;
    logic                   r_pend;
    logic [1:0]             r_err_flag;

    logic                   w_rd_en;
    logic                   w_last_word;
    logic                   w_drain_done;
    logic                   w_last_batch;
    logic                   w_ln_wrap;
    logic                   w_pend_taken;
    logic                   w_req_busy;
    logic                   w_status;
    logic                   w_act_vld;

    assign w_inst       = inst_fields_t'(bus.inst_data);
    assign w_inst_legal = inst_is_legal(w_inst);
    assign w_batch_len  = WID_BLEN'(w_inst.tp) * WID_BLEN'(w_inst.tn) * WID_BLEN'(N_TILE);

    assign w_last_word  = (r_cnt_word == r_batch_len - WID_BLEN'(1));
    assign w_ln_wrap    = (r_cnt_ln == r_n_ln - WID_INST_LN'(1));
    assign w_last_batch = w_ln_wrap && (r_cnt_lp == r_n_lp - WID_INST_LP'(1));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rd_en      = 1'b0;
        w_drain_done = 1'b0;
        w_status     = (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
            end
            ST_WAIT_REQ: begin
                if (bus.act_in_req || r_pend) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_rd_en = 1'b1;
                if (w_last_word) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt == WID_DRAIN'(RD_LAT - 1)) begin
                    w_drain_done = 1'b1;
                    if (w_last_batch) begin
                        w_state_next = ST_IDLE;
                    end else if (r_pend) begin
                        // Queued request goes straight back to issuing.
                        w_state_next = ST_ISSUE;
                    end else begin
                        w_state_next = ST_WAIT_REQ;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // A new instruction aborts whatever is running.
        if (bus.inst_en) begin
            w_state_next = w_inst_legal ? ST_WAIT_REQ : ST_IDLE;
        end
    end

    // A pending request is consumed when it is what launches the next batch.
    assign w_pend_taken = r_pend && ((r_state == ST_WAIT_REQ) ||
                                     (w_drain_done && !w_last_batch));
    assign w_req_busy   = bus.act_in_req && ((r_state == ST_ISSUE) || (r_state == ST_DRAIN));

    // ------------------------------------------------------------------
    // Counters, pending request, sticky errors
    // ------------------------------------------------------------------
    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) begin
            r_batch_len <= '0;
            r_n_ln      <= '0;
            r_n_lp      <= '0;
            r_cnt_word  <= '0;
            r_cnt_ln    <= '0;
            r_cnt_lp    <= '0;
            r_drain_cnt <= '0;
            r_pend      <= 1'b0;
            r_err_flag  <= 2'b00;
        end else if (bus.inst_en) begin
            r_batch_len <= w_batch_len;
            r_n_ln      <= w_inst.ln;
            r_n_lp      <= w_inst.lp;
            r_cnt_word  <= '0;
            r_cnt_ln    <= '0;
            r_cnt_lp    <= '0;
            r_drain_cnt <= '0;
            r_pend      <= 1'b0;
            r_err_flag  <= {~w_inst_legal, 1'b0};
        end else begin
            if (r_state == ST_ISSUE) begin
                r_cnt_word <= w_last_word ? '0 : r_cnt_word + WID_BLEN'(1);
            end

            if (r_state == ST_DRAIN) begin
                r_drain_cnt <= w_drain_done ? '0 : r_drain_cnt + WID_DRAIN'(1);
            end

            if (w_drain_done) begin
                if (w_last_batch) begin
                    r_cnt_ln <= '0;
                    r_cnt_lp <= '0;
                end else if (w_ln_wrap) begin
                    r_cnt_ln <= '0;
                    r_cnt_lp <= r_cnt_lp + WID_INST_LP'(1);
                end else begin
                    r_cnt_ln <= r_cnt_ln + WID_INST_LN'(1);
                end
            end

            if (w_pend_taken) begin
                // A request landing on the same cycle refills the slot.
                r_pend <= bus.act_in_req;
            end else if (w_drain_done && w_last_batch) begin
                r_pend <= 1'b0;
            end else if (w_req_busy) begin
                if (r_pend) begin
                    r_err_flag[0] <= 1'b1;
                end else begin
                    r_pend <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Valid alignment with the SRAM read latency
    // ------------------------------------------------------------------
    sblk_vld_pipe #(
        .DEPTH (RD_LAT)
    ) u_vld_pipe (
        .clk_l   (clk_l),
        .rst     (rst),
        .i_flush (bus.inst_en),
        .i_vld   (w_rd_en),
        .o_vld   (w_act_vld)
    );

    assign bus.act_src_rd_en   = w_rd_en;
    assign bus.act_src_rd_addr = w_rd_en ? (WID_SRCADDR'(r_cnt_lp) * WID_SRCADDR'(r_batch_len)
                                            + WID_SRCADDR'(r_cnt_word))
                                         : '0;
    assign bus.act_in_vld      = w_act_vld;
    assign bus.act_in          = bus.act_src_rd_data;
    assign bus.status_feed     = w_status;
    assign bus.err_flag        = r_err_flag;

`ifdef SBLK_FEED_CHKSUM_EN
    // ------------------------------------------------------------------
    // Per-batch XOR checksum. The last valid word of a batch coincides
    // with the final DRAIN cycle, so it is folded in there and the result
    // is latched into a separate register, leaving the accumulator free
    // for a back-to-back batch.
    // ------------------------------------------------------------------
    logic [2*WID_ACT-1:0] r_chk_acc;
    logic [2*WID_ACT-1:0] r_batch_chksum;
    logic                 r_chksum_vld;
    logic [2*WID_ACT-1:0] w_chk_word;

    assign w_chk_word = w_act_vld ? bus.act_src_rd_data : '0;

    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) begin
            r_chk_acc      <= '0;
            r_batch_chksum <= '0;
            r_chksum_vld   <= 1'b0;
        end else if (bus.inst_en) begin
            r_chk_acc    <= '0;
            r_chksum_vld <= 1'b0;
        end else begin
            r_chksum_vld <= w_drain_done;
            if (w_drain_done) begin
                r_batch_chksum <= r_chk_acc ^ w_chk_word;
                r_chk_acc      <= '0;
            end else begin
                r_chk_acc <= r_chk_acc ^ w_chk_word;
            end
        end
    end

    assign bus.batch_chksum = r_batch_chksum;
    assign bus.chksum_vld   = r_chksum_vld;
`endif

endmodule

// File: tb/tb_sblk_act_feeder.sv
// -----------------------------------------------------------------------------
// tb_sblk_act_feeder
// Scoreboard bench: every request pushes its expected read addresses and data
// words; a negedge monitor pops them as act_src_rd_en / act_in_vld appear.
// The source SRAM is modelled with content mem[a] = a+1 and RD_LAT latency.
// -----------------------------------------------------------------------------
module tb_sblk_act_feeder;
    import sblk_pkg::*;

    localparam int N_TILE      = 4;
    localparam int WID_ACT     = 8;
    localparam int WID_SRCADDR = 12;
    localparam int RD_LAT      = 2;
    localparam int WID_W       = 2 * WID_ACT;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sblk_act_feeder_if #(.WID_ACT(WID_ACT), .WID_SRCADDR(WID_SRCADDR)) bus ();

    sblk_act_feeder #(
        .N_TILE      (N_TILE),
        .WID_ACT     (WID_ACT),
        .WID_SRCADDR (WID_SRCADDR),
        .RD_LAT      (RD_LAT)
    ) dut (
        .clk_l (clk),
        .rst   (rst),
        .bus   (bus)
    );

    // ---------------- source SRAM model ----------------
    function automatic logic [WID_W-1:0] sram_word(input int a);
        return WID_W'(a + 1);
    endfunction

    logic [WID_W-1:0] sram_pipe [RD_LAT];
    always @(posedge clk) begin
        sram_pipe[0] <= bus.act_src_rd_en ? sram_word(int'(bus.act_src_rd_addr)) : WID_W'(16'hdead);
        for (int i = 1; i < RD_LAT; i++) sram_pipe[i] <= sram_pipe[i-1];
    end
    assign bus.act_src_rd_data = sram_pipe[RD_LAT-1];

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int               exp_addr_q[$];
    logic [WID_W-1:0] exp_data_q[$];
    int               rd_cyc_q[$];
    int               vld_cyc_q[$];
    int               n_rd  = 0;
    int               n_vld = 0;
    int               n_chk_pulse = 0;
    int               chk_pulse_cyc = 0;
    logic [WID_W-1:0] chk_pulse_val = '0;

    int m_blen, m_nln, m_nlp, m_ln, m_lp;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.act_src_rd_en) begin
                n_rd++;
                rd_cyc_q.push_back(cyc);
                if (exp_addr_q.size() == 0) begin
                    chk_val("rd_unexpected", 32'(exp_addr_q.size()), 32'd1);
                end else begin
                    chk_val("rd_addr", 32'(bus.act_src_rd_addr), 32'(exp_addr_q.pop_front()));
                end
            end
            if (bus.act_in_vld) begin
                n_vld++;
                vld_cyc_q.push_back(cyc);
                if (exp_data_q.size() == 0) begin
                    chk_val("vld_unexpected", 32'(exp_data_q.size()), 32'd1);
                end else begin
                    chk_val("act_in", 32'(bus.act_in), 32'(exp_data_q.pop_front()));
                end
            end
`ifdef SBLK_FEED_CHKSUM_EN
            if (bus.chksum_vld) begin
                n_chk_pulse++;
                chk_pulse_cyc = cyc;
                chk_pulse_val = bus.batch_chksum;
            end
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_inst(input int tn, input int tm, input int tp, input int ln, input int lp);
        bus.inst_data = {3'(lp), 3'(ln), 2'(tp), 3'(tm), 3'(tn)};
        bus.inst_en   = 1'b1;
        tick();
        bus.inst_en   = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        m_blen = tp * tn * N_TILE;
        m_nln  = ln;
        m_nlp  = lp;
        m_ln   = 0;
        m_lp   = 0;
        $display("inst: tn=%0d tm=%0d tp=%0d ln=%0d lp=%0d (cycle %0d)", tn, tm, tp, ln, lp, cyc);
    endtask

    task automatic pulse_req();
        bus.act_in_req = 1'b1;
        tick();
        bus.act_in_req = 1'b0;
    endtask

    task automatic do_req();
        int base;
        base = m_lp * m_blen;
        for (int w = 0; w < m_blen; w++) begin
            exp_addr_q.push_back((base + w) % (1 << WID_SRCADDR));
            exp_data_q.push_back(sram_word((base + w) % (1 << WID_SRCADDR)));
        end
        $display("req: ln=%0d lp=%0d base=%0d len=%0d (cycle %0d)", m_ln, m_lp, base, m_blen, cyc);
        m_ln++;
        if (m_ln == m_nln) begin
            m_ln = 0;
            m_lp++;
        end
        pulse_req();
    endtask

    task automatic wait_drained(input int budget);
        int k = 0;
        while ((exp_addr_q.size() != 0 || exp_data_q.size() != 0) && k < budget) begin
            tick();
            k++;
        end
        chk_val("drain_timeout", 32'(exp_data_q.size()), 32'd0);
    endtask

    task automatic wait_idle(input int budget, output int t_idle);
        int k = 0;
        while (bus.status_feed && k < budget) begin
            tick();
            k++;
        end
        t_idle = cyc;
        chk_val("idle_timeout", 32'(bus.status_feed), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int t_idle;
        int n0;
        int nv;

        rst            = 1'b1;
        bus.inst_data  = '0;
        bus.inst_en    = 1'b0;
        bus.act_in_req = 1'b0;
        repeat (3) tick();

        // Reset state
        chk_val("rst_rd_en",  32'(bus.act_src_rd_en), 32'd0);
        chk_val("rst_vld",    32'(bus.act_in_vld),    32'd0);
        chk_val("rst_status", 32'(bus.status_feed),   32'd0);
        chk_val("rst_err",    32'(bus.err_flag),      32'd0);
        chk_val("rst_addr",   32'(bus.act_src_rd_addr), 32'd0);
        rst = 1'b0;
        tick();

        // T1: tn=2 tp=2 ln=1 lp=1, request at cycle 10
        load_inst(2, 1, 2, 1, 1);
        chk_val("t1_status_rise", 32'(bus.status_feed), 32'd1);
        while (cyc < 10) tick();
        rd_cyc_q.delete();
        vld_cyc_q.delete();
        do_req();
        wait_idle(100, t_idle);
        chk_val("t1_rd_count",  32'(rd_cyc_q.size()),  32'd16);
        chk_val("t1_rd_first",  32'(rd_cyc_q[0]),      32'd11);
        chk_val("t1_rd_last",   32'(rd_cyc_q[15]),     32'd26);
        chk_val("t1_vld_count", 32'(vld_cyc_q.size()), 32'd16);
        chk_val("t1_vld_first", 32'(vld_cyc_q[0]),     32'd13);
        chk_val("t1_vld_last",  32'(vld_cyc_q[15]),    32'd28);
        chk_val("t1_idle_cyc",  32'(t_idle),           32'd29);
        chk_val("t1_err",       32'(bus.err_flag),     32'd0);

        // T2: tn=1 tp=1 ln=2 lp=2 -> bases 0,0,4,4
        load_inst(1, 0, 1, 2, 2);
        for (int b = 0; b < 4; b++) begin
            do_req();
            wait_drained(50);
            chk_val("t2_status", 32'(bus.status_feed), (b < 3) ? 32'd1 : 32'd0);
        end
        n0 = n_rd;
        pulse_req();
        repeat (6) tick();
        chk_val("t2_idle_req_ignored", 32'(n_rd - n0), 32'd0);

        // T3: pending request and overflow
        load_inst(2, 0, 2, 2, 1);
        rd_cyc_q.delete();
        do_req();
        repeat (2) tick();
        do_req();
        repeat (2) tick();
        pulse_req();
        chk_val("t3_err_overflow", 32'(bus.err_flag), 32'd1);
        wait_drained(100);
        chk_val("t3_status", 32'(bus.status_feed), 32'd0);
        chk_val("t3_rd_count", 32'(rd_cyc_q.size()), 32'd32);
        chk_val("t3_pend_gap", 32'(rd_cyc_q[16] - rd_cyc_q[15]), 32'(RD_LAT + 1));
        chk_val("t3_err_sticky", 32'(bus.err_flag), 32'd1);

        // T4: abort at the 5th issued word
        load_inst(2, 0, 2, 1, 1);
        chk_val("t4_err_cleared", 32'(bus.err_flag), 32'd0);
        n0 = n_rd;
        do_req();
        repeat (4) tick();
        load_inst(1, 0, 2, 1, 1);
        chk_val("t4_words_issued", 32'(n_rd - n0), 32'd5);
        chk_val("t4_rd_en_drop", 32'(bus.act_src_rd_en), 32'd0);
        nv = n_vld;
        repeat (8) tick();
        chk_val("t4_no_stale_vld", 32'(n_vld - nv), 32'd0);
        do_req();
        wait_idle(100, t_idle);

        // T5: illegal configuration (tp = 0)
        load_inst(1, 0, 0, 1, 1);
        chk_val("t5_err_cfg", 32'(bus.err_flag), 32'd2);
        chk_val("t5_status", 32'(bus.status_feed), 32'd0);
        n0 = n_rd;
        pulse_req();
        repeat (6) tick();
        chk_val("t5_req_ignored", 32'(n_rd - n0), 32'd0);
        chk_val("t5_status_hold", 32'(bus.status_feed), 32'd0);

`ifdef SBLK_FEED_CHKSUM_EN
        // T6: checksum over data 0x0001..0x0010
        load_inst(2, 0, 2, 1, 1);
        n_chk_pulse = 0;
        vld_cyc_q.delete();
        do_req();
        wait_idle(100, t_idle);
        repeat (3) tick();
        chk_val("t6_chk_pulses", 32'(n_chk_pulse),   32'd1);
        chk_val("t6_chk_value",  32'(chk_pulse_val), 32'h0010);
        chk_val("t6_chk_timing", 32'(chk_pulse_cyc), 32'(vld_cyc_q[vld_cyc_q.size()-1] + 1));
`endif

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
